// File: rtl/fetch_unit_if.sv
// Bus bundles for the fetch stage: instruction-memory request/response and the
// decode/datapath side (current instruction out, retire/redirect in).

interface fetch_imem_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

interface fetch_dp_if;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        advance;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (output instr, op, instr_valid, pc, pcplus4, fault, fault_pc,
                    input  advance, redirect, redirect_pc);
    modport slave  (input  instr, op, instr_valid, pc, pcplus4, fault, fault_pc,
                    output advance, redirect, redirect_pc);
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: holds the PC, fetches one word per instruction over
// a req/ack handshake and presents it to decode until the datapath retires it.

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_imem_if.master  imem,
    fetch_dp_if.master    dp
);

    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_FAULT
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [31:0]      r_fault_pc;
    logic             r_req;
    logic             r_valid;
    logic             r_fault;
    logic [31:0]      w_pcplus4;

    assign w_pcplus4 = r_pc + 32'd4;

    // Flag outputs are registered alongside the state so they always match it.
    // NOTE: all state here uses non-blocking assignments so every branch sees the
    // pre-edge values of r_pc/r_wait_cnt regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_wait_cnt <= '0;
            r_fault_pc <= '0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_req      <= 1'b1;
                    r_wait_cnt <= '0;
                end
                ST_FETCH: begin
                    if (imem.ack) begin
                        r_instr    <= imem.rdata;
                        r_state    <= ST_HOLD;
                        r_req      <= 1'b0;
                        r_valid    <= 1'b1;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == LAST_WAIT) begin
                        // Exactly WAIT_LIMIT ack-less cycles have elapsed.
                        r_state    <= ST_FAULT;
                        r_req      <= 1'b0;
                        r_fault    <= 1'b1;
                        r_fault_pc <= r_pc;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (dp.advance) begin
                        if (!dp.redirect) begin
                            r_pc    <= w_pcplus4;
                            r_state <= ST_FETCH;
                            r_req   <= 1'b1;
                            r_valid <= 1'b0;
                        end else if (dp.redirect_pc[1:0] == 2'b00) begin
                            r_pc    <= dp.redirect_pc;
                            r_state <= ST_FETCH;
                            r_req   <= 1'b1;
                            r_valid <= 1'b0;
                        end else begin
                            // Misaligned target: pc keeps the branch's own address.
                            r_state    <= ST_FAULT;
                            r_valid    <= 1'b0;
                            r_fault    <= 1'b1;
                            r_fault_pc <= dp.redirect_pc;
                        end
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_FAULT;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    assign imem.req       = r_req;
    assign imem.addr      = r_pc;
    assign dp.instr       = r_instr;
    assign dp.op          = r_instr[31:26];
    assign dp.instr_valid = r_valid;
    assign dp.pc          = r_pc;
    assign dp.pcplus4     = w_pcplus4;
    assign dp.fault       = r_fault;
    assign dp.fault_pc    = r_fault_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, multi-cycle corner
// sequences, then randomized transactions against a transaction-level model.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          WAIT_LIMIT = 16;

    logic clk;
    logic reset;

    fetch_imem_if u_imem ();
    fetch_dp_if   u_dp ();

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .imem  (u_imem.master),
        .dp    (u_dp.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        adv;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_fault_pc;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic adv,
                         input logic redir, input logic [31:0] rpc);
        u_imem.ack        = ack;
        u_imem.rdata      = rdata;
        u_dp.advance      = adv;
        u_dp.redirect     = redir;
        u_dp.redirect_pc  = rpc;
    endtask

    // Asserts reset mid-cycle, checks the async clear, releases away from an edge.
    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst_req",      u_imem.req,     0);
        check("rst_valid",    u_dp.instr_valid, 0);
        check("rst_fault",    u_dp.fault,     0);
        check("rst_op",       u_dp.op,        0);
        check("rst_pc",       u_dp.pc,        RESET_PC);
        check("rst_fault_pc", u_dp.fault_pc,  0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Reference memory contents: any deterministic scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    logic [31:0] exp_pc;
    logic [31:0] exp_word;
    logic [31:0] tgt;
    logic [31:0] rnd;
    int          req_cycles;

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;

        // ---------------- directed vector table ----------------
        vecs[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0};
        vecs[1]  = '{1'b1, 32'h8C08_0004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h8C08_0004, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h8C08_0004, 32'h0};
        vecs[3]  = '{1'b1, 32'h2009_0005, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h2009_0005, 32'h0};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h2009_0005, 32'h0};
        vecs[5]  = '{1'b1, 32'h0109_5020, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0109_5020, 32'h0};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0109_5020, 32'h0};
        vecs[7]  = '{1'b1, 32'h1109_0003, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h1109_0003, 32'h0};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h40,       1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h1109_0003, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h1109_0003, 32'h0};
        vecs[10] = '{1'b1, 32'hAC08_0008, 1'b1, 1'b1, 32'h80,       1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hAC08_0008, 32'h0};
        vecs[11] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'hAC08_0008, 32'h0};
        vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hAC08_0008, 32'h0};
        vecs[13] = '{1'b1, 32'h0800_0010, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0800_0010, 32'h0};
        vecs[14] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0800_0010, 32'h0};
        vecs[15] = '{1'b1, 32'h8C0A_000C, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h8C0A_000C, 32'h0};
        vecs[16] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h42,       1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h8C0A_000C, 32'h42};
        vecs[17] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h8C0A_000C, 32'h42};
        vecs[18] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h8C0A_000C, 32'h42};

        do_reset();
        check("idle_req", u_imem.req, 0);
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].adv, vecs[i].redir, vecs[i].rpc);
            step();
            check($sformatf("v%0d_req", i),      u_imem.req,       vecs[i].e_req);
            check($sformatf("v%0d_addr", i),     u_imem.addr,      vecs[i].e_pc);
            check($sformatf("v%0d_valid", i),    u_dp.instr_valid, vecs[i].e_valid);
            check($sformatf("v%0d_fault", i),    u_dp.fault,       vecs[i].e_fault);
            check($sformatf("v%0d_pc", i),       u_dp.pc,          vecs[i].e_pc);
            check($sformatf("v%0d_pcplus4", i),  u_dp.pcplus4,     vecs[i].e_pc + 32'd4);
            check($sformatf("v%0d_instr", i),    u_dp.instr,       vecs[i].e_instr);
            check($sformatf("v%0d_op", i),       u_dp.op,          {26'h0, vecs[i].e_instr[31:26]});
            check($sformatf("v%0d_fault_pc", i), u_dp.fault_pc,    vecs[i].e_fault_pc);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // ---------------- async reset mid-FETCH, stray ack in IDLE ----------------
        #2;
        do_reset();
        step();
        check("mf_req", u_imem.req, 1);
        #2;
        do_reset();
        drive(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("refetch_req",   u_imem.req,       1);
        check("refetch_addr",  u_imem.addr,      RESET_PC);
        check("stray_valid",   u_dp.instr_valid, 0);
        check("stray_instr",   u_dp.instr,       0);

        // ---------------- timeout after exactly WAIT_LIMIT cycles ----------------
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (u_imem.req) req_cycles++;
            if (u_dp.fault) break;
            step();
        end
        check("to_req_cycles", req_cycles,       WAIT_LIMIT);
        check("to_fault",      u_dp.fault,       1);
        check("to_fault_pc",   u_dp.fault_pc,    RESET_PC);
        check("to_req",        u_imem.req,       0);
        check("to_valid",      u_dp.instr_valid, 0);

        // ---------------- reset out of FAULT, ack in final wait cycle ----------------
        #2;
        do_reset();
        step();
        for (int i = 0; i < WAIT_LIMIT - 1; i++) step();
        check("late_req",   u_imem.req,  1);
        check("late_fault", u_dp.fault,  0);
        drive(1'b1, 32'h3C01_1234, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("late_valid", u_dp.instr_valid, 1);
        check("late_fault2", u_dp.fault,      0);
        check("late_instr", u_dp.instr,       32'h3C01_1234);

        // ---------------- randomized transactions vs. reference model ----------------
        exp_pc   = RESET_PC;
        exp_word = 32'h3C01_1234;
        for (int n = 0; n < 60; n++) begin
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                drive(1'($urandom), $urandom, 1'b0, 1'($urandom), $urandom);
                step();
                check("r_hold_valid", u_dp.instr_valid, 1);
                check("r_hold_instr", u_dp.instr,       exp_word);
                check("r_hold_pc",    u_dp.pc,          exp_pc);
            end
            rnd = $urandom;
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            if (n == 10) tgt = 32'hFFFF_FFFC;
            drive(1'b0, 32'h0, 1'b1, (rnd[1:0] == 2'b00) || (n == 10), tgt);
            step();
            exp_pc = ((rnd[1:0] == 2'b00) || (n == 10)) ? tgt : exp_pc + 32'd4;
            check("r_adv_req",   u_imem.req,       1);
            check("r_adv_addr",  u_imem.addr,      exp_pc);
            check("r_adv_valid", u_dp.instr_valid, 0);
            for (int w = 0; w < int'($urandom_range(0, 5)); w++) begin
                drive(1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom);
                step();
                check("r_wait_req",  u_imem.req,  1);
                check("r_wait_addr", u_imem.addr, exp_pc);
            end
            exp_word = mem_word(exp_pc);
            drive(1'b1, exp_word, 1'b0, 1'b0, 32'h0);
            step();
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            check("r_cap_valid",   u_dp.instr_valid, 1);
            check("r_cap_req",     u_imem.req,       0);
            check("r_cap_instr",   u_dp.instr,       exp_word);
            check("r_cap_op",      u_dp.op,          {26'h0, exp_word[31:26]});
            check("r_cap_pc",      u_dp.pc,          exp_pc);
            check("r_cap_pcplus4", u_dp.pcplus4,     exp_pc + 32'd4);
            check("r_cap_fault",   u_dp.fault,       0);
        end

        tgt = $urandom;
        tgt[0] = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b1, tgt);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("mis_fault",    u_dp.fault,       1);
        check("mis_fault_pc", u_dp.fault_pc,    tgt);
        check("mis_pc",       u_dp.pc,          exp_pc);
        check("mis_req",      u_imem.req,       0);
        check("mis_valid",    u_dp.instr_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
